asm_line_parser: RTL and testbench

Upstream front end of the mnemonic-to-opcode converter. Walks an ASCII source memory line by line and streams each mnemonic, NUL-terminated, into the converter over its Start/Name/Ready handshake. It then collects the resulting opcode, parses an optional hex operand, and writes one packed instruction word {opcode, operand} per line into program memory. It owns sequencing, syntax checking and converter timeout.

---
 rtl/asm_pkg.sv | 39 +++
 rtl/ascii_class.sv | 29 ++
 rtl/asm_line_parser.sv | 265 ++++++++++++++++++++++++++
 tb/tb_asm_line_parser.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/asm_pkg.sv
`default_nettype none
// ============================================================================
// asm_pkg
// Shared constants and types for the assembler line parser.
//   - ASCII control characters used by the source grammar
//   - Parser state encoding
//   - Instruction word field widths and mnemonic length limit
// Revision: 1.0
// ============================================================================
package asm_pkg;

  localparam logic [7:0] NUL = 8'h00;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] SP  = 8'h20;

  // Instruction word is {opcode, operand}, 8 bits in total.
  localparam int OPC_WIDTH = 3;
  localparam int OPR_WIDTH = 8 - OPC_WIDTH;

  // Longest mnemonic the converter accepts.
  localparam int NAME_MAX = 9;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_SKIP_WS   = 4'd1,
    S_OC_START  = 4'd2,
    S_OC_GAP    = 4'd3,
    S_SEND_NAME = 4'd4,
    S_WAIT_OC   = 4'd5,
    S_SKIP_SP   = 4'd6,
    S_OPERAND   = 4'd7,
    S_TAIL      = 4'd8,
    S_WRITE     = 4'd9,
    S_DONE      = 4'd10,
    S_ERROR     = 4'd11
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ascii_class.sv
`default_nettype none
// ============================================================================
// ascii_class
// Combinational character classifier for the source stream.
//   ch        in   8  ASCII character
//   is_letter out  1  'A'..'Z'
//   is_hex    out  1  '0'..'9' or 'A'..'F'
//   hex_val   out  4  nibble value (meaningful only when is_hex)
// Revision: 1.0
// ============================================================================
module ascii_class (
  input  logic [7:0] ch,
  output logic       is_letter,
  output logic       is_hex,
  output logic [3:0] hex_val
);

  logic is_digit;
  logic is_af;

  assign is_digit  = (ch >= 8'h30) && (ch <= 8'h39);
  assign is_af     = (ch >= 8'h41) && (ch <= 8'h46);
  assign is_letter = (ch >= 8'h41) && (ch <= 8'h5A);
  assign is_hex    = is_digit || is_af;
  // 'A' is 0x41, so its low nibble plus 9 yields 10.
  assign hex_val   = is_digit ? ch[3:0] : (ch[3:0] + 4'd9);

endmodule
`default_nettype wire

// File: rtl/asm_line_parser.sv
`default_nettype none
// ============================================================================
// asm_line_parser
// Walks an ASCII source memory line by line, streams each mnemonic to the
// mnemonic-to-opcode converter, parses an optional hex operand and writes
// one {opcode, operand} word per line into program memory.
//   Clk/Rst         clock, asynchronous active-high reset
//   Go              start assembly from source address 0
//   Busy/Done/Err   run status; ErrAddr = source address of the fault
//   SrcAddr/SrcData asynchronous-read source memory port
//   OcStart/OcName  converter start pulse and NUL-terminated name stream
//   OcReady/OcOpcode converter status and result
//   PmWe/PmAddr/PmData program memory write port
//   InstrCount      number of instructions written
// Revision: 1.0
// ============================================================================
module asm_line_parser
  import asm_pkg::*;
#(
  parameter int SRC_AW     = 8,
  parameter int PM_AW      = 5,
  parameter int OPC_W      = OPC_WIDTH,
  parameter int OC_TIMEOUT = 1023
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Go,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [SRC_AW-1:0] ErrAddr,
  output logic [SRC_AW-1:0] SrcAddr,
  input  logic [7:0]        SrcData,
  output logic              OcStart,
  output logic [7:0]        OcName,
  input  logic              OcReady,
  input  logic [OPC_W-1:0]  OcOpcode,
  output logic              PmWe,
  output logic [PM_AW-1:0]  PmAddr,
  output logic [7:0]        PmData,
  output logic [PM_AW:0]    InstrCount
);

  localparam int OPR_W = 8 - OPC_W;
  localparam int TO_W  = $clog2(OC_TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(OC_TIMEOUT - 1);
  localparam logic [PM_AW:0]   PM_DEPTH = {1'b1, {PM_AW{1'b0}}};
  localparam logic [7:0]       OPR_MAX  = 8'((1 << OPR_W) - 1);

  state_t             state;
  logic [3:0]         name_len;
  logic               pend_err;
  logic [TO_W-1:0]    wait_cnt;
  logic [OPC_W-1:0]   opc;
  logic [OPR_W-1:0]   acc;
  logic               second;
  logic               gap_seen;

  logic       is_letter;
  logic       is_hex;
  logic [3:0] hex_val;
  logic       is_sp;
  logic       is_lf;
  logic       is_nul;
  logic       is_eol;
  logic       addr_last;
  logic       name_full;
  logic [7:0] acc_next;
  logic       adv;
  logic       bad;
  logic       fail;

  ascii_class u_class (
    .ch        (SrcData),
    .is_letter (is_letter),
    .is_hex    (is_hex),
    .hex_val   (hex_val)
  );

  assign is_sp     = (SrcData == SP);
  assign is_lf     = (SrcData == LF);
  assign is_nul    = (SrcData == NUL);
  assign is_eol    = is_lf || is_nul;
  assign addr_last = &SrcAddr;
  assign name_full = (name_len == 4'(NAME_MAX));
  assign acc_next  = {acc[3:0], hex_val};

  // The converter samples Start and each name character on the clock edge
  // that ends the cycle they are driven in, so both are decoded from the
  // current state and source character rather than delayed by a register.
  assign OcStart = (state == S_OC_START) && OcReady;
  assign OcName  = (state == S_SEND_NAME && is_letter && !name_full) ? SrcData : NUL;
  assign PmWe    = (state == S_WRITE) && (InstrCount != PM_DEPTH);
  assign PmData  = {opc, acc};

  // adv: consume the current character; bad: character or condition that
  // aborts the run. A consume at the top address would wrap, which is fatal.
  always_comb begin
    adv = 1'b0;
    bad = 1'b0;
    case (state)
      S_SKIP_WS: begin
        if (is_sp || is_lf)          adv = 1'b1;
        else if (!is_nul && !is_letter) bad = 1'b1;
      end
      S_SEND_NAME: begin
        if (is_letter && !name_full) adv = 1'b1;
      end
      S_WAIT_OC: begin
        if (!OcReady && wait_cnt == TO_LAST) bad = 1'b1;
      end
      S_SKIP_SP: begin
        if (is_sp)                      adv = 1'b1;
        else if (is_hex && gap_seen)    adv = 1'b1;
        else if (!is_eol)               bad = 1'b1;
      end
      S_OPERAND: begin
        if (is_hex) begin
          if (second || acc_next > OPR_MAX) bad = 1'b1;
          else                              adv = 1'b1;
        end else if (is_sp)   adv = 1'b1;
        else if (!is_eol)     bad = 1'b1;
      end
      S_TAIL: begin
        if (is_sp)            adv = 1'b1;
        else if (!is_eol)     bad = 1'b1;
      end
      S_WRITE: begin
        if (InstrCount == PM_DEPTH) bad = 1'b1;
        else if (is_lf)             adv = 1'b1;
      end
      default: ;
    endcase
    fail = bad || (adv && addr_last);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= S_IDLE;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Err        <= 1'b0;
      ErrAddr    <= '0;
      SrcAddr    <= '0;
      PmAddr     <= '0;
      InstrCount <= '0;
      name_len   <= '0;
      pend_err   <= 1'b0;
      wait_cnt   <= '0;
      opc        <= '0;
      acc        <= '0;
      second     <= 1'b0;
      gap_seen   <= 1'b0;
    end else begin
      if (adv && !addr_last) SrcAddr <= SrcAddr + 1'b1;

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (Go) begin
            state      <= S_SKIP_WS;
            Busy       <= 1'b1;
            Done       <= 1'b0;
            Err        <= 1'b0;
            ErrAddr    <= '0;
            SrcAddr    <= '0;
            PmAddr     <= '0;
            InstrCount <= '0;
          end
        end
        S_SKIP_WS: begin
          if (is_nul) begin
            state <= S_DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else if (is_letter) begin
            state <= S_OC_START;
          end
        end
        S_OC_START: begin
          name_len <= '0;
          pend_err <= 1'b0;
          if (OcReady) state <= S_OC_GAP;
        end
        S_OC_GAP: state <= S_SEND_NAME;
        S_SEND_NAME: begin
          if (is_letter && !name_full) begin
            name_len <= name_len + 1'b1;
          end else begin
            // An over-long name is still terminated so the converter
            // returns to idle; the error is raised once it does.
            if (is_letter) begin
              pend_err <= 1'b1;
              ErrAddr  <= SrcAddr;
            end
            wait_cnt <= '0;
            state    <= S_WAIT_OC;
          end
        end
        S_WAIT_OC: begin
          if (OcReady) begin
            opc      <= OcOpcode;
            gap_seen <= 1'b0;
            if (pend_err) begin
              state <= S_ERROR;
              Busy  <= 1'b0;
              Err   <= 1'b1;
            end else begin
              state <= S_SKIP_SP;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_SKIP_SP: begin
          if (is_sp) begin
            gap_seen <= 1'b1;
          end else if (is_eol) begin
            acc   <= '0;
            state <= S_WRITE;
          end else begin
            acc    <= OPR_W'(hex_val);
            second <= 1'b0;
            state  <= S_OPERAND;
          end
        end
        S_OPERAND: begin
          if (is_hex) begin
            acc    <= acc_next[OPR_W-1:0];
            second <= 1'b1;
          end else if (is_sp) begin
            state <= S_TAIL;
          end else begin
            state <= S_WRITE;
          end
        end
        S_TAIL: begin
          if (is_eol) state <= S_WRITE;
        end
        S_WRITE: begin
          if (InstrCount != PM_DEPTH) begin
            PmAddr     <= PmAddr + 1'b1;
            InstrCount <= InstrCount + 1'b1;
            if (is_nul) begin
              state <= S_DONE;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end else begin
              state <= S_SKIP_WS;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      if (fail) begin
        state   <= S_ERROR;
        Busy    <= 1'b0;
        Err     <= 1'b1;
        ErrAddr <= SrcAddr;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_asm_line_parser.sv
`default_nettype none
// ============================================================================
// tb_asm_line_parser
// Directed bench for asm_line_parser with a behavioural converter model
// (LDA=1, STA=2, HLT=7) and a scoreboard of expected program-memory writes.
// Revision: 1.0
// ============================================================================
module tb_asm_line_parser;

  localparam int OC_TO = 1023;

  logic       Clk;
  logic       Rst;
  logic       Go;
  logic       Busy, Done, Err;
  logic [7:0] ErrAddr, SrcAddr, SrcData;
  logic       OcStart;
  logic [7:0] OcName;
  logic       OcReady;
  logic [2:0] OcOpcode;
  logic       PmWe;
  logic [4:0] PmAddr;
  logic [7:0] PmData;
  logic [5:0] InstrCount;

  logic [7:0] mem [0:255];
  assign SrcData = mem[SrcAddr];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [12:0] exp_q [$];

  asm_line_parser #(.SRC_AW(8), .PM_AW(5), .OPC_W(3), .OC_TIMEOUT(OC_TO)) dut (
    .Clk(Clk), .Rst(Rst), .Go(Go),
    .Busy(Busy), .Done(Done), .Err(Err), .ErrAddr(ErrAddr),
    .SrcAddr(SrcAddr), .SrcData(SrcData),
    .OcStart(OcStart), .OcName(OcName), .OcReady(OcReady), .OcOpcode(OcOpcode),
    .PmWe(PmWe), .PmAddr(PmAddr), .PmData(PmData), .InstrCount(InstrCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Converter model: Idle -> Init1 -> GetName -> Lookup -> Idle.
  logic        oc_mute;
  logic [1:0]  m_st;
  logic [31:0] m_name;
  logic [3:0]  m_len;
  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      m_st     <= 2'd0;
      m_name   <= '0;
      m_len    <= '0;
      OcReady  <= 1'b1;
      OcOpcode <= '0;
    end else begin
      case (m_st)
        2'd0: if (OcStart) begin
          m_st <= 2'd1; OcReady <= 1'b0; m_name <= '0; m_len <= '0;
        end
        2'd1: m_st <= 2'd2;
        2'd2: if (OcName == 8'h00) m_st <= 2'd3;
              else begin m_name <= {m_name[23:0], OcName}; m_len <= m_len + 1'b1; end
        default: begin
          if (m_len == 4'd3 && m_name[23:0] == "LDA") begin
            OcOpcode <= 3'd1; OcReady <= 1'b1; m_st <= 2'd0;
          end else if (m_len == 4'd3 && m_name[23:0] == "STA") begin
            OcOpcode <= 3'd2; OcReady <= 1'b1; m_st <= 2'd0;
          end else if (m_len == 4'd3 && m_name[23:0] == "HLT") begin
            OcOpcode <= 3'd7; OcReady <= 1'b1; m_st <= 2'd0;
          end else if (!oc_mute) begin
            OcOpcode <= 3'd0; OcReady <= 1'b1; m_st <= 2'd0;
          end
        end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge Clk) begin
    if (PmWe) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {51'd0, PmAddr, PmData}, 64'hDEAD);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        chk("pm_addr", 64'(PmAddr), 64'(e[12:8]));
        chk("pm_data", 64'(PmData), 64'(e[7:0]));
      end
    end
  end

  task automatic load(input string s);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) mem[i] = s[i];
  endtask

  task automatic go();
    @(negedge Clk); Go = 1'b1;
    @(negedge Clk); Go = 1'b0;
  endtask

  task automatic run_to_end(input int budget);
    int n = 0;
    while (!(Done || Err) && n < budget) begin @(negedge Clk); n++; end
    chk("end_bound", 64'(Done | Err), 64'd1);
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (!OcStart && n < budget) begin @(negedge Clk); n++; end
    chk("start_bound", 64'(OcStart), 64'd1);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({Busy, Done, Err, ErrAddr, SrcAddr, OcStart, OcName,
                PmWe, PmAddr, PmData, InstrCount});
  endfunction

  initial begin
    Rst = 1'b1; Go = 1'b0; oc_mute = 1'b0;
    load("");
    repeat (2) @(negedge Clk);
    chk("reset_outputs", all_outs(), 64'd0);
    Rst = 1'b0;
    @(negedge Clk);
    chk("idle_outputs", all_outs(), 64'd0);

    // Two lines, operand and no operand.
    load("LDA 1F\nHLT");
    exp_q.push_back({5'd0, 8'h3F});
    exp_q.push_back({5'd1, 8'hE0});
    go();
    chk("busy_after_go", 64'(Busy), 64'd1);
    run_to_end(200);
    chk("t1_done", 64'({Done, Err, Busy}), 64'b100);
    chk("t1_count", 64'(InstrCount), 64'd2);
    chk("t1_drained", 64'(exp_q.size()), 64'd0);

    // Blank lines, trailing spaces, name stream timing.
    load("  \n\nSTA 05  ");
    exp_q.push_back({5'd0, 8'h45});
    go();
    wait_start(50);
    @(negedge Clk);
    chk("gap_no_start", 64'(OcStart), 64'd0);
    @(negedge Clk); chk("name_S", 64'(OcName), 64'h53);
    @(negedge Clk); chk("name_T", 64'(OcName), 64'h54);
    @(negedge Clk); chk("name_A", 64'(OcName), 64'h41);
    @(negedge Clk); chk("name_nul", 64'(OcName), 64'h00);
    run_to_end(200);
    chk("t2_done", 64'({Done, Err}), 64'b10);
    chk("t2_count", 64'(InstrCount), 64'd1);
    chk("t2_drained", 64'(exp_q.size()), 64'd0);

    // Operand value out of range.
    load("LDA 20\n");
    go();
    run_to_end(200);
    chk("t3_err", 64'({Done, Err, Busy}), 64'b010);
    chk("t3_erraddr", 64'(ErrAddr), 64'd5);
    chk("t3_count", 64'(InstrCount), 64'd0);

    // Ten-letter mnemonic: NUL replaces the tenth letter.
    load("ABCDEFGHIJ\n");
    go();
    wait_start(50);
    @(negedge Clk);
    for (int i = 0; i < 9; i++) begin
      logic [7:0] e;
      e = 8'h41 + 8'(i);
      @(negedge Clk);
      chk("long_name_char", 64'(OcName), 64'(e));
    end
    @(negedge Clk);
    chk("long_name_nul", 64'(OcName), 64'h00);
    chk("long_name_err_pending", 64'(Err), 64'd0);
    run_to_end(200);
    chk("t4_err", 64'(Err), 64'd1);
    chk("t4_erraddr", 64'(ErrAddr), 64'd9);

    // Converter never answers: timeout.
    oc_mute = 1'b1;
    load("XYZ\n");
    go();
    wait_start(50);
    begin
      int k = 0;
      while (!Err && k < OC_TO + 100) begin @(negedge Clk); k++; end
      chk("timeout_cycle", 64'(k), 64'(3 + 3 + OC_TO));
    end
    chk("t5_erraddr", 64'(ErrAddr), 64'd3);
    @(negedge Clk); Rst = 1'b1; oc_mute = 1'b0;
    @(negedge Clk); Rst = 1'b0;

    // Program memory overflow after 32 writes.
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 33; i++) begin
      mem[4*i] = 8'h48; mem[4*i+1] = 8'h4C; mem[4*i+2] = 8'h54; mem[4*i+3] = 8'h0A;
    end
    for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), 8'hE0});
    go();
    run_to_end(2000);
    chk("t6_err", 64'({Done, Err}), 64'b01);
    chk("t6_count", 64'(InstrCount), 64'd32);
    chk("t6_erraddr", 64'(ErrAddr), 64'd131);
    chk("t6_drained", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a name, then a clean rerun.
    load("LDA 1F\nHLT");
    go();
    wait_start(50);
    @(negedge Clk);
    @(negedge Clk);
    chk("mid_name_L", 64'(OcName), 64'h4C);
    #2 Rst = 1'b1;
    #1 chk("async_reset_outputs", all_outs(), 64'd0);
    @(negedge Clk); Rst = 1'b0;
    exp_q.push_back({5'd0, 8'h3F});
    exp_q.push_back({5'd1, 8'hE0});
    go();
    run_to_end(200);
    chk("t7_done", 64'({Done, Err}), 64'b10);
    chk("t7_count", 64'(InstrCount), 64'd2);
    chk("t7_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
